// File: rtl/round_scoreboard.sv
// Round scoreboard: per-player round wins, match target and winner for the game-flow FSM.
// Optional macro DRAW_POINT_EN: a simultaneous double death awards a point to both players.
module round_scoreboard #(
    parameter int unsigned WINS_DEFAULT = 3,
    parameter int unsigned WINS_MAX     = 9,
    parameter int unsigned SW           = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [2:0]    game_state,
    input  logic          TankDead_1,
    input  logic          TankDead_2,
    input  logic          wins_inc,
    input  logic          wins_dec,
    output logic [SW-1:0] p1_score,
    output logic [SW-1:0] p2_score,
    output logic [SW-1:0] wins_need,
    output logic          round_done,
    output logic [1:0]    round_result,
    output logic [1:0]    match_winner
);

    localparam logic [2:0] GS_START = 3'd0;
    localparam logic [2:0] GS_TANK  = 3'd1;
    localparam logic [2:0] GS_COOL  = 3'd2;
    localparam logic [2:0] GS_PLAY  = 3'd3;
    localparam logic [2:0] GS_CHECK = 3'd4;
    localparam logic [2:0] GS_END   = 3'd5;

    localparam logic [SW-1:0] SCORE_MAX = '1;
    localparam logic [SW-1:0] NEED_DEF  = SW'(WINS_DEFAULT);
    localparam logic [SW-1:0] NEED_MAX  = SW'(WINS_MAX);
    localparam logic [SW-1:0] NEED_MIN  = SW'(1);

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_P1   = 2'd1;
    localparam logic [1:0] RES_P2   = 2'd2;
    localparam logic [1:0] RES_DRAW = 2'd3;

    logic [SW-1:0] p1_q, p1_d;
    logic [SW-1:0] p2_q, p2_d;
    logic [SW-1:0] need_q, need_d;
    logic          done_q, done_d;
    logic [1:0]    result_q, result_d;
    logic [1:0]    winner_q, winner_d;
    logic          armed_q, armed_d;
    logic          in_start_q, in_start_d;
    logic          p1_hit, p2_hit;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] x);
        return (x == SCORE_MAX) ? x : x + SW'(1);
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_q       <= '0;
            p2_q       <= '0;
            need_q     <= NEED_DEF;
            done_q     <= 1'b0;
            result_q   <= RES_NONE;
            winner_q   <= RES_NONE;
            armed_q    <= 1'b1;
            in_start_q <= 1'b1;
        end else begin
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            need_q     <= need_d;
            done_q     <= done_d;
            result_q   <= result_d;
            winner_q   <= winner_d;
            armed_q    <= armed_d;
            in_start_q <= in_start_d;
        end
    end

    assign p1_hit = TankDead_2;
    assign p2_hit = TankDead_1;

    // Next-state logic, decoded from the FSM's current state
    always_comb begin
        p1_d       = p1_q;
        p2_d       = p2_q;
        need_d     = need_q;
        done_d     = 1'b0;
        result_d   = result_q;
        winner_d   = RES_NONE;
        armed_d    = armed_q;
        in_start_d = (game_state == GS_START);

        case (game_state)
            GS_START: begin
                p1_d     = '0;
                p2_d     = '0;
                result_d = RES_NONE;
                armed_d  = 1'b1;
                // Entering the menu restores the default target before any key is honoured
                if (!in_start_q) begin
                    need_d = NEED_DEF;
                end else if (wins_inc && !wins_dec) begin
                    need_d = (need_q >= NEED_MAX) ? NEED_MAX : need_q + SW'(1);
                end else if (wins_dec && !wins_inc) begin
                    need_d = (need_q <= NEED_MIN) ? NEED_MIN : need_q - SW'(1);
                end
            end
            GS_PLAY: begin
                if (armed_q && (p1_hit || p2_hit)) begin
                    done_d  = 1'b1;
                    armed_d = 1'b0;
                    if (p1_hit && p2_hit) begin
                        result_d = RES_DRAW;
`ifdef DRAW_POINT_EN
                        p1_d = sat_inc(p1_q);
                        p2_d = sat_inc(p2_q);
`endif
                    end else if (p1_hit) begin
                        result_d = RES_P1;
                        p1_d     = sat_inc(p1_q);
                    end else begin
                        result_d = RES_P2;
                        p2_d     = sat_inc(p2_q);
                    end
                end else if (!TankDead_1 && !TankDead_2) begin
                    armed_d = 1'b1;
                end
            end
            GS_END: begin
                if ((p1_q >= need_q) && (p2_q >= need_q)) begin
                    winner_d = RES_DRAW;
                end else if (p1_q >= need_q) begin
                    winner_d = RES_P1;
                end else if (p2_q >= need_q) begin
                    winner_d = RES_P2;
                end
            end
            GS_TANK, GS_COOL, GS_CHECK: begin
            end
            default: begin
                winner_d   = winner_q;
                in_start_d = in_start_q;
            end
        endcase
    end

    assign p1_score     = p1_q;
    assign p2_score     = p2_q;
    assign wins_need    = need_q;
    assign round_done   = done_q;
    assign round_result = result_q;
    assign match_winner = winner_q;

endmodule

// File: tb/tb_round_scoreboard.sv
// Scoreboard bench for round_scoreboard: directed plan plus random game_state/death traffic.
module tb_round_scoreboard;

    localparam int WD   = 3;
    localparam int WMAX = 9;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] game_state = 3'd0;
    logic       TankDead_1 = 1'b0;
    logic       TankDead_2 = 1'b0;
    logic       wins_inc = 1'b0;
    logic       wins_dec = 1'b0;
    logic [3:0] p1_score, p2_score, wins_need;
    logic       round_done;
    logic [1:0] round_result, match_winner;

    round_scoreboard #(.WINS_DEFAULT(WD), .WINS_MAX(WMAX), .SW(4)) dut (
        .clk(clk), .reset_n(reset_n), .game_state(game_state),
        .TankDead_1(TankDead_1), .TankDead_2(TankDead_2),
        .wins_inc(wins_inc), .wins_dec(wins_dec),
        .p1_score(p1_score), .p2_score(p2_score), .wins_need(wins_need),
        .round_done(round_done), .round_result(round_result), .match_winner(match_winner)
    );

    always #5 clk = ~clk;

    typedef struct { int p1; int p2; int need; int rd; int rr; int mw; } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (game rules in plain integers)
    int m_p1, m_p2, m_need, m_rr, m_mw, m_armed, m_last_gs;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_p1 = 0; m_p2 = 0; m_need = WD; m_rr = 0; m_mw = 0; m_armed = 1; m_last_gs = 0;
    endtask

    function automatic int add_sat(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    task automatic model_step(input int gs, input int d1, input int d2, input int inc, input int dec);
        exp_t e;
        int rd = 0;
        if (gs >= 6) begin
            // unknown FSM codes freeze everything; only the round pulse drops
        end else begin
            m_mw = 0;
            if (gs == 0) begin
                m_p1 = 0; m_p2 = 0; m_rr = 0; m_armed = 1;
                if (m_last_gs != 0)          m_need = WD;
                else if (inc == 1 && dec == 0) m_need = (m_need + 1 > WMAX) ? WMAX : m_need + 1;
                else if (dec == 1 && inc == 0) m_need = (m_need - 1 < 1) ? 1 : m_need - 1;
            end else if (gs == 3) begin
                if (m_armed == 1 && (d1 == 1 || d2 == 1)) begin
                    rd = 1; m_armed = 0;
                    if (d1 == 1 && d2 == 1) begin
                        m_rr = 3;
`ifdef DRAW_POINT_EN
                        m_p1 = add_sat(m_p1); m_p2 = add_sat(m_p2);
`endif
                    end else if (d2 == 1) begin
                        m_rr = 1; m_p1 = add_sat(m_p1);
                    end else begin
                        m_rr = 2; m_p2 = add_sat(m_p2);
                    end
                end else if (d1 == 0 && d2 == 0) begin
                    m_armed = 1;
                end
            end else if (gs == 5) begin
                if (m_p1 >= m_need && m_p2 >= m_need) m_mw = 3;
                else if (m_p1 >= m_need)              m_mw = 1;
                else if (m_p2 >= m_need)              m_mw = 2;
            end
            m_last_gs = gs;
        end
        e.p1 = m_p1; e.p2 = m_p2; e.need = m_need; e.rd = rd; e.rr = m_rr; e.mw = m_mw;
        exp_q.push_back(e);
    endtask

    // Drive one clock's worth of inputs and predict the post-edge outputs
    task automatic cycle(input int gs, input int d1, input int d2, input int inc, input int dec);
        @(negedge clk);
        game_state = 3'(gs);
        TankDead_1 = 1'(d1);
        TankDead_2 = 1'(d2);
        wins_inc   = 1'(inc);
        wins_dec   = 1'(dec);
        model_step(gs, d1, d2, inc, dec);
    endtask

    // Sample just after the edge that the last queued prediction refers to
    task automatic spot(input string name, input int act_sel, input int req);
        int act;
        @(posedge clk);
        #2;
        case (act_sel)
            0: act = int'(p1_score);
            1: act = int'(p2_score);
            2: act = int'(wins_need);
            3: act = int'(match_winner);
            default: act = int'(round_result);
        endcase
        chk(name, act, req);
    endtask

    // Monitor: compare every DUT output set against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("p1_score",     int'(p1_score),     e.p1);
                chk("p2_score",     int'(p2_score),     e.p2);
                chk("wins_need",    int'(wins_need),    e.need);
                chk("round_done",   int'(round_done),   e.rd);
                chk("round_result", int'(round_result), e.rr);
                chk("match_winner", int'(match_winner), e.mw);
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_p1", int'(p1_score), 0);
        chk("rst_p2", int'(p2_score), 0);
        chk("rst_need", int'(wins_need), WD);
        chk("rst_done", int'(round_done), 0);
        chk("rst_result", int'(round_result), 0);
        chk("rst_winner", int'(match_winner), 0);
        reset_n = 1'b1;

        // Target adjust: saturate high then low
        for (int i = 0; i < 8; i++) begin cycle(0, 0, 0, 1, 0); cycle(0, 0, 0, 0, 0); end
        cycle(0, 0, 0, 1, 1);
        spot("need_max", 2, 9);
        for (int i = 0; i < 10; i++) begin cycle(0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 0); end
        spot("need_min", 2, 1);
        cycle(0, 0, 0, 1, 0);

        // P1 wins a round with TankDead_2 held for five cycles
        cycle(1, 0, 0, 1, 0); cycle(2, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(3, 0, 1, 0, 0);
        spot("p1_once", 0, 1);
        cycle(4, 0, 1, 0, 0); cycle(3, 0, 0, 0, 0); cycle(3, 0, 1, 0, 0);
        cycle(4, 0, 1, 0, 0); cycle(5, 0, 0, 0, 0); cycle(5, 0, 0, 0, 0);
        spot("winner_p1", 3, 1);
        cycle(0, 0, 0, 0, 0);
        spot("p1_cleared", 0, 0);

        // TankDead_1 held across CHECK_SCORE, then dropped and raised again
        cycle(1, 0, 0, 0, 0); cycle(2, 0, 0, 0, 0);
        cycle(3, 1, 0, 0, 0); cycle(4, 1, 0, 0, 0); cycle(3, 1, 0, 0, 0);
        cycle(3, 0, 0, 0, 0); cycle(3, 1, 0, 0, 0);
        spot("p2_twice", 1, 2);

        // Simultaneous double death
        cycle(3, 0, 0, 0, 0); cycle(3, 1, 1, 0, 0);
        spot("draw_result", 4, 3);
`ifdef DRAW_POINT_EN
        spot("draw_p1", 0, 1);
`else
        spot("draw_p1", 0, 0);
`endif
        cycle(4, 1, 1, 0, 0); cycle(5, 0, 0, 0, 0); cycle(5, 0, 0, 0, 0);

        // Score saturation at 15
        cycle(1, 0, 0, 0, 0); cycle(3, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin cycle(3, 0, 1, 0, 0); cycle(3, 0, 0, 0, 0); end
        spot("p1_sat", 0, 15);

        // Random traffic, biased towards PLAY_GAME
        for (int i = 0; i < 600; i++) begin
            int gs;
            gs = int'($urandom_range(0, 10));
            if (gs > 7) gs = 3;
            cycle(gs, ($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 3) == 0) ? 1 : 0,
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of PLAY_GAME with p1 at 3
        cycle(0, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0); cycle(3, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin cycle(3, 0, 1, 0, 0); cycle(3, 0, 0, 0, 0); end
        spot("p1_pre_reset", 0, 3);
        @(posedge clk);
        #3;
        game_state = 3'd0; TankDead_1 = 1'b0; TankDead_2 = 1'b0; wins_inc = 1'b0; wins_dec = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_p1", int'(p1_score), 0);
        chk("async_p2", int'(p2_score), 0);
        chk("async_need", int'(wins_need), WD);
        chk("async_done", int'(round_done), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
